// File: rtl/bcd_digit_packer.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_packer
// Purpose  : Collects decimal digits (most significant first, one per
//            valid/ready handshake) into an N-digit right-aligned packed-BCD
//            word and presents it with a digit count and an error flag.
// Options  : BCD_DIGIT_PACKER_ASCII_EN - when defined, i_digit is an 8-bit
//            ASCII character ('0'..'9'); otherwise a 4-bit binary digit.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_packer #(
    parameter int N = 3
) (
    input  logic                   i_clock,
    input  logic                   i_aresetn,
`ifdef BCD_DIGIT_PACKER_ASCII_EN
    input  logic [7:0]             i_digit,
`else
    input  logic [3:0]             i_digit,
`endif
    input  logic                   i_last,
    input  logic                   i_valid,
    output logic                   o_ready,
    output logic [4*N-1:0]         o_bcd,
    output logic [$clog2(N+1)-1:0] o_ndigits,
    output logic                   o_error,
    output logic                   o_valid,
    input  logic                   i_ready
);

    // Internal count must reach N+1 so overflowed words stay distinguishable.
    localparam int NW = $clog2(N + 1);
    localparam int CW = $clog2(N + 2);
    localparam logic [CW-1:0] c_N   = CW'(N);
    localparam logic [CW-1:0] c_NP1 = CW'(N + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [4*N-1:0]    r_shift;
    logic [4*N-1:0]    w_shift_next;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_ndig;
    logic              r_err;
    logic [3:0]        w_dval;
    logic              w_dvalid;
    logic              w_accept;
    logic              w_release;

    // Decode the incoming digit; anything outside 0..9 becomes 0 and is flagged.
`ifdef BCD_DIGIT_PACKER_ASCII_EN
    always_comb begin
        w_dvalid = (i_digit >= 8'h30) && (i_digit <= 8'h39);
        w_dval   = w_dvalid ? i_digit[3:0] : 4'd0;
    end
`else
    always_comb begin
        w_dvalid = (i_digit <= 4'd9);
        w_dval   = w_dvalid ? i_digit : 4'd0;
    end
`endif

    // A single-digit word simply replaces its only digit.
    generate
        if (N == 1) begin : g_shift_single
            assign w_shift_next = w_dval;
        end else begin : g_shift_multi
            assign w_shift_next = {r_shift[4*N-5:0], w_dval};
        end
    endgenerate

    assign w_accept  = i_valid && o_ready;
    assign w_release = o_valid && i_ready;

    // State register.
    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake outputs; ready/valid depend on state alone.
    always_comb begin
        w_state_next = r_state;
        o_ready      = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            S_IDLE, S_COLLECT: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    w_state_next = i_last ? S_OUTPUT : S_COLLECT;
                end
            end
            S_OUTPUT: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Word datapath: shift digits in, track count and sticky error, clear on release.
    always_ff @(posedge i_clock or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_shift <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_shift <= w_shift_next;
            if (r_count < c_NP1) begin
                r_count <= r_count + 1'b1;
            end
            // Losing the leading digit once the word is full is an error.
            r_err   <= r_err || !w_dvalid || (r_count >= c_N);
        end else if (w_release) begin
            r_shift <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end
    end

    assign w_ndig    = (r_count > c_N) ? c_N : r_count;
    assign o_ndigits = NW'(w_ndig);
    assign o_bcd     = r_shift;
    assign o_error   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_bcd_digit_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_digit_packer
// Purpose  : Directed self-checking bench for bcd_digit_packer (N=3, binary).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_digit_packer;

    localparam int N = 3;

    logic        i_clock;
    logic        i_aresetn;
    logic [3:0]  i_digit;
    logic        i_last;
    logic        i_valid;
    logic        o_ready;
    logic [11:0] o_bcd;
    logic [1:0]  o_ndigits;
    logic        o_error;
    logic        o_valid;
    logic        i_ready;

    int checks;
    int errors;

    bcd_digit_packer #(.N(N)) dut (
        .i_clock   (i_clock),
        .i_aresetn (i_aresetn),
        .i_digit   (i_digit),
        .i_last    (i_last),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_bcd     (o_bcd),
        .o_ndigits (o_ndigits),
        .o_error   (o_error),
        .o_valid   (o_valid),
        .i_ready   (i_ready)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Offer one digit for exactly one rising edge; returns 1 time unit after it.
    task automatic send(input logic [3:0] d, input logic last);
        i_digit = d;
        i_last  = last;
        i_valid = 1'b1;
        @(posedge i_clock);
        #1;
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_digit = 4'd0;
    endtask

    task automatic test_reset();
        i_aresetn = 1'b0;
        i_valid   = 1'b0;
        i_last    = 1'b0;
        i_digit   = 4'd0;
        i_ready   = 1'b1;
        repeat (2) @(posedge i_clock);
        #1;
        checks++;
        if ({o_valid, o_ready, o_error, o_ndigits, o_bcd} !== {1'b0, 1'b1, 1'b0, 2'd0, 12'h000}) begin
            errors++;
            $display("FAIL reset_state got v=%b r=%b e=%b n=%0d bcd=%h exp v=0 r=1 e=0 n=0 bcd=000",
                     o_valid, o_ready, o_error, o_ndigits, o_bcd);
        end
        i_aresetn = 1'b1;
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_full_word();
        send(4'd1, 1'b0);
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_mid got v=%b r=%b exp v=0 r=1", o_valid, o_ready);
        end
        send(4'd2, 1'b0);
        send(4'd3, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_latency got v=%b r=%b exp v=1 r=0", o_valid, o_ready);
        end
        checks++;
        if (o_bcd !== 12'h123 || o_ndigits !== 2'd3 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL full_word got bcd=%h n=%0d e=%b exp bcd=123 n=3 e=0", o_bcd, o_ndigits, o_error);
        end
        @(posedge i_clock);
        #1;
        checks++;
        if ({o_valid, o_ready, o_error, o_ndigits, o_bcd} !== {1'b0, 1'b1, 1'b0, 2'd0, 12'h000}) begin
            errors++;
            $display("FAIL full_release got v=%b r=%b e=%b n=%0d bcd=%h exp v=0 r=1 e=0 n=0 bcd=000",
                     o_valid, o_ready, o_error, o_ndigits, o_bcd);
        end
    endtask

    task automatic test_short_word();
        send(4'd4, 1'b0);
        send(4'd2, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_bcd !== 12'h042 || o_ndigits !== 2'd2 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL short_word got v=%b bcd=%h n=%0d e=%b exp v=1 bcd=042 n=2 e=0",
                     o_valid, o_bcd, o_ndigits, o_error);
        end
        // Handshake at this edge; the single digit goes in at the very next edge.
        @(posedge i_clock);
        #1;
        send(4'd7, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_bcd !== 12'h007 || o_ndigits !== 2'd1 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back got v=%b bcd=%h n=%0d e=%b exp v=1 bcd=007 n=1 e=0",
                     o_valid, o_bcd, o_ndigits, o_error);
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_overflow();
        send(4'd1, 1'b0);
        send(4'd2, 1'b0);
        send(4'd3, 1'b0);
        checks++;
        if (o_error !== 1'b0 || o_ndigits !== 2'd3 || o_bcd !== 12'h123) begin
            errors++;
            $display("FAIL overflow_full got bcd=%h n=%0d e=%b exp bcd=123 n=3 e=0", o_bcd, o_ndigits, o_error);
        end
        send(4'd4, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_bcd !== 12'h234 || o_ndigits !== 2'd3 || o_error !== 1'b1) begin
            errors++;
            $display("FAIL overflow got v=%b bcd=%h n=%0d e=%b exp v=1 bcd=234 n=3 e=1",
                     o_valid, o_bcd, o_ndigits, o_error);
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_invalid_digit();
        send(4'd5, 1'b0);
        send(4'hB, 1'b0);
        checks++;
        if (o_error !== 1'b1 || o_bcd !== 12'h050) begin
            errors++;
            $display("FAIL invalid_mid got bcd=%h e=%b exp bcd=050 e=1", o_bcd, o_error);
        end
        send(4'd6, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_bcd !== 12'h506 || o_ndigits !== 2'd3 || o_error !== 1'b1) begin
            errors++;
            $display("FAIL invalid_digit got v=%b bcd=%h n=%0d e=%b exp v=1 bcd=506 n=3 e=1",
                     o_valid, o_bcd, o_ndigits, o_error);
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_backpressure();
        i_ready = 1'b0;
        send(4'd7, 1'b0);
        send(4'd8, 1'b1);
        // Offer a competing digit throughout the stall; it must be ignored.
        i_digit = 4'd9;
        i_last  = 1'b1;
        i_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({o_valid, o_ready, o_error, o_ndigits, o_bcd} !== {1'b1, 1'b0, 1'b0, 2'd2, 12'h078}) begin
                errors++;
                $display("FAIL backpressure_hold[%0d] got v=%b r=%b e=%b n=%0d bcd=%h exp v=1 r=0 e=0 n=2 bcd=078",
                         i, o_valid, o_ready, o_error, o_ndigits, o_bcd);
            end
            @(posedge i_clock);
            #1;
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clock);
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_bcd !== 12'h000) begin
            errors++;
            $display("FAIL backpressure_release got v=%b r=%b bcd=%h exp v=0 r=1 bcd=000", o_valid, o_ready, o_bcd);
        end
        send(4'd1, 1'b1);
        checks++;
        if (o_bcd !== 12'h001 || o_ndigits !== 2'd1 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_after got bcd=%h n=%0d e=%b exp bcd=001 n=1 e=0", o_bcd, o_ndigits, o_error);
        end
        @(posedge i_clock);
        #1;
    endtask

    task automatic test_reset_midword();
        send(4'd9, 1'b0);
        send(4'd8, 1'b0);
        #2;
        i_aresetn = 1'b0;
        #1;
        checks++;
        if ({o_valid, o_ready, o_error, o_ndigits, o_bcd} !== {1'b0, 1'b1, 1'b0, 2'd0, 12'h000}) begin
            errors++;
            $display("FAIL reset_async got v=%b r=%b e=%b n=%0d bcd=%h exp v=0 r=1 e=0 n=0 bcd=000",
                     o_valid, o_ready, o_error, o_ndigits, o_bcd);
        end
        i_aresetn = 1'b1;
        @(posedge i_clock);
        #1;
        send(4'd3, 1'b1);
        checks++;
        if (o_valid !== 1'b1 || o_bcd !== 12'h003 || o_ndigits !== 2'd1 || o_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_after got v=%b bcd=%h n=%0d e=%b exp v=1 bcd=003 n=1 e=0",
                     o_valid, o_bcd, o_ndigits, o_error);
        end
        @(posedge i_clock);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_full_word();
        test_short_word();
        test_overflow();
        test_invalid_digit();
        test_backpressure();
        test_reset_midword();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
